// File: rtl/buffer_pkg.sv
// Shared state encoding and sizing helpers for the single-clock sync_buffer FIFO.
package buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    RDY   = 2'b01,
    FULL  = 2'b10
  } state_t;

  function automatic int buf_depth(input int aw);
    return 1 << aw;
  endfunction

  // One extra bit so the occupancy can represent DEPTH itself.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/buffer_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read; no reset, contents survive flush/reset.
module buffer_mem
  import buffer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = buf_depth(AW);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_buffer.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky errors, flush and empty bypass.
// data_out is registered (1-cycle read latency); loads on full are dropped unless paired with a consume.
module sync_buffer
  import buffer_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int addr_len  = 3,
  parameter int AE_THRESH = 1,
  parameter int AF_THRESH = 6,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic [bit_width-1:0] data_in,
  input  logic                 consume,
  output logic [bit_width-1:0] data_out,
  output logic                 data_valid,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [addr_len:0]    count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int CW    = cnt_width(addr_len);
  localparam int DEPTH = buf_depth(addr_len);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  state_t                state_q;
  logic [addr_len-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [bit_width-1:0]  dout_q;
  logic                  dvld_q;
  logic                  ovf_q, unf_q;

  logic                  is_empty, is_full, bypass, wr_acc, rd_acc, ovf_set, unf_set;
  logic [bit_width-1:0]  mem_rdata;

  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == DEPTH_C);
    bypass   = BYPASS && load && consume && is_empty;
    wr_acc   = load && (!is_full || consume) && !bypass;
    rd_acc   = consume && !is_empty;
    ovf_set  = load && is_full && !consume;
    // Without bypass, a consume on empty is ignored even when a load lands that cycle.
    unf_set  = consume && is_empty && !bypass;
    count_d  = count_q;
    if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
  end

  buffer_mem #(
    .WIDTH (bit_width),
    .AW    (addr_len)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !clr),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvld_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (clr) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dvld_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dvld_q  <= rd_acc || bypass;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + addr_len'(1);
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + addr_len'(1);
        dout_q   <= mem_rdata;
      end else if (bypass) begin
        dout_q   <= data_in;
      end
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
      case (state_q)
        EMPTY: if (wr_acc && !rd_acc) state_q <= (count_d == DEPTH_C) ? FULL : RDY;
        RDY: begin
          if (count_q == CW'(1) && rd_acc && !wr_acc) state_q <= EMPTY;
          else if (count_q == DEPTH_C - CW'(1) && wr_acc && !rd_acc) state_q <= FULL;
        end
        FULL:    if (rd_acc && !wr_acc) state_q <= RDY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign data_out     = dout_q;
  assign data_valid   = dvld_q;
  assign count        = count_q;
  assign empty        = is_empty;
  assign full         = is_full;
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_buffer.sv
// Scoreboard bench for sync_buffer: directed stimulus pushes expected words, a monitor pops them on data_valid.
module tb_sync_buffer;

  logic        clk = 1'b0;
  logic        rst, clr, load, consume;
  logic [15:0] data_in, data_out;
  logic        data_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0]  count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mq[$];
  bit          movf, munf;

  sync_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .load         (load),
    .data_in      (data_in),
    .consume      (consume),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst === 1'b1 && data_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_data_valid", 32'd1, 32'd0);
      else check("data_out_order", {16'd0, data_out}, {16'd0, exp_q.pop_front()});
    end
  end

  // One clock of stimulus; the reference queue is updated from pre-edge state.
  task automatic step(input bit ld, input bit cs, input logic [15:0] din, input bit cl);
    bit m_empty, m_full, byp, rd, wr;
    @(negedge clk); #1;
    load = ld; consume = cs; data_in = din; clr = cl;
    if (cl) begin
      mq.delete();
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      m_empty = (mq.size() == 0);
      m_full  = (mq.size() == 8);
      byp     = ld && cs && m_empty;
      if (byp) begin
        exp_q.push_back(din);
      end else begin
        rd = cs && !m_empty;
        wr = ld && (!m_full || cs);
        if (rd) exp_q.push_back(mq.pop_front());
        if (wr) mq.push_back(din);
        if (ld && m_full && !cs) movf = 1'b1;
        if (cs && m_empty) munf = 1'b1;
      end
    end
    @(posedge clk); #1;
    check("count", {28'd0, count}, mq.size());
    check("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
    check("full", {31'd0, full}, {31'd0, mq.size() == 8});
    check("almost_empty", {31'd0, almost_empty}, {31'd0, mq.size() <= 1});
    check("almost_full", {31'd0, almost_full}, {31'd0, mq.size() >= 6});
    check("overflow", {31'd0, overflow}, {31'd0, movf});
    check("underflow", {31'd0, underflow}, {31'd0, munf});
    load = 1'b0; consume = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b0; consume = 1'b0; data_in = '0;
    movf = 1'b0; munf = 1'b0;
    #1;
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_almost_empty", {31'd0, almost_empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_almost_full", {31'd0, almost_full}, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    #20 rst = 1'b1;

    // Fill then drain
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 16'(i), 1'b0);
      if (i == 6) check("af_at_6", {31'd0, almost_full}, 32'd1);
    end
    check("full_after_8", {31'd0, full}, 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check("empty_after_drain", {31'd0, empty}, 32'd1);
    check("last_drained", {16'd0, data_out}, 32'h0008);

    // Interleaved traffic wrapping the pointers, count 0..3
    for (int i = 0; i < 20; i++) begin
      step((i % 6) < 3, (i % 6) >= 3, 16'h0100 + 16'(i), 1'b0);
    end
    step(1'b0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);

    // Full with simultaneous load+consume
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0011 + 16'(i), 1'b0);
    step(1'b1, 1'b1, 16'hBEEF, 1'b0);
    check("simul_full_count", {28'd0, count}, 32'd8);
    check("simul_oldest_out", {16'd0, data_out}, 32'h0011);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    check("beef_last", {16'd0, data_out}, 32'h0000BEEF);

    // Overflow: dropped word must never appear; then underflow
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0021 + 16'(i), 1'b0);
    step(1'b1, 1'b0, 16'hDEAD, 1'b0);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    check("post_ovf_last", {16'd0, data_out}, 32'h0028);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    check("underflow_set", {31'd0, underflow}, 32'd1);

    // Bypass on empty
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    check("bypass_data", {16'd0, data_out}, 32'h1234);
    check("bypass_valid", {31'd0, data_valid}, 32'd1);
    check("bypass_count", {28'd0, count}, 32'd0);

    // Flush with five words queued
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0031 + 16'(i), 1'b0);
    check("pre_flush_count", {28'd0, count}, 32'd5);
    step(1'b1, 1'b1, 16'h0999, 1'b1);
    check("flush_data_held", {16'd0, data_out}, 32'h1234);
    check("flush_valid", {31'd0, data_valid}, 32'd0);
    check("flush_ovf", {31'd0, overflow}, 32'd0);
    check("flush_unf", {31'd0, underflow}, 32'd0);
    step(1'b1, 1'b0, 16'h5A5A, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    check("post_flush_word", {16'd0, data_out}, 32'h5A5A);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0041 + 16'(i), 1'b0);
    step(1'b1, 1'b0, 16'h0DAD, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    mq.delete(); exp_q.delete(); movf = 1'b0; munf = 1'b0;
    check("mid_rst_count", {28'd0, count}, 32'd0);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_ae", {31'd0, almost_empty}, 32'd1);
    check("mid_rst_full", {31'd0, full}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check("mid_rst_data", {16'd0, data_out}, 32'd0);
    check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
    @(negedge clk); #2;
    rst = 1'b1;
    step(1'b1, 1'b0, 16'h0077, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    check("post_rst_word", {16'd0, data_out}, 32'h0077);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
